// File: rtl/tl_ul_reg_bridge.sv
// TileLink-UL slave to single-cycle-ack register bus bridge, one transaction in flight.
// Define TL_REG_BRIDGE_TIMEOUT_EN to add an 8-bit bus timeout that answers with denied=1.
module tl_ul_reg_bridge #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned SRC_W  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              auto_in_a_valid,
   output logic              auto_in_a_ready,
   input  logic [2:0]        auto_in_a_bits_opcode,
   input  logic [2:0]        auto_in_a_bits_param,
   input  logic [1:0]        auto_in_a_bits_size,
   input  logic [SRC_W-1:0]  auto_in_a_bits_source,
   input  logic [ADDR_W-1:0] auto_in_a_bits_address,
   input  logic [3:0]        auto_in_a_bits_mask,
   input  logic [31:0]       auto_in_a_bits_data,
   input  logic              auto_in_a_bits_corrupt,
   output logic              auto_in_d_valid,
   input  logic              auto_in_d_ready,
   output logic [2:0]        auto_in_d_bits_opcode,
   output logic [1:0]        auto_in_d_bits_size,
   output logic [SRC_W-1:0]  auto_in_d_bits_source,
   output logic [31:0]       auto_in_d_bits_data,
   output logic              auto_in_d_bits_denied,
   output logic              reg_req,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_be,
   input  logic              reg_ack,
   input  logic [31:0]       reg_rdata
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_ACK         = 3'd0;
   localparam logic [2:0] OP_ACK_DATA    = 3'd1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q;
   logic [1:0]          size_q;
   logic [SRC_W-1:0]    source_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [MASK_W-1:0]   mask_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                corrupt_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                denied_q;

   logic a_fire, a_is_put, a_supported, bus_done, timeout_c;

   assign a_fire      = auto_in_a_valid && (state_q == IDLE);
   assign a_is_put    = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                        (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
   assign a_supported = a_is_put || (auto_in_a_bits_opcode == OP_GET);
   assign bus_done    = (state_q == BUS) && reg_ack;

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;
   logic [CNT_W-1:0] cnt_q;

   // Counter reads k in the (k+1)-th ack-less bus cycle; it reaches 255 as the bus gives up.
   assign timeout_c = (state_q == BUS) && !reg_ack && (cnt_q == CNT_W'(254));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (a_fire) begin
         cnt_q <= '0;
      end else if ((state_q == BUS) && !reg_ack) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (auto_in_a_valid) begin
               if (!a_supported || (a_is_put && auto_in_a_bits_corrupt)) state_d = RESP;
               else                                                     state_d = BUS;
            end
         end
         BUS:     if (reg_ack || timeout_c) state_d = RESP;
         RESP:    if (auto_in_d_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request holding registers and response payload
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q      <= '0;
         size_q    <= '0;
         source_q  <= '0;
         addr_q    <= '0;
         mask_q    <= '0;
         wdata_q   <= '0;
         corrupt_q <= 1'b0;
         rdata_q   <= '0;
         denied_q  <= 1'b0;
      end else if (a_fire) begin
         op_q      <= auto_in_a_bits_opcode;
         size_q    <= auto_in_a_bits_size;
         source_q  <= auto_in_a_bits_source;
         addr_q    <= auto_in_a_bits_address;
         mask_q    <= auto_in_a_bits_mask;
         wdata_q   <= auto_in_a_bits_data;
         corrupt_q <= auto_in_a_bits_corrupt;
         rdata_q   <= '0;
         denied_q  <= !a_supported;
      end else if (bus_done) begin
         rdata_q   <= (op_q == OP_GET) ? reg_rdata : '0;
         denied_q  <= 1'b0;
      end else if (timeout_c) begin
         rdata_q   <= '0;
         denied_q  <= 1'b1;
      end
   end

   // Output decode from state and holding registers
   always_comb begin
      auto_in_a_ready       = 1'b0;
      auto_in_d_valid       = 1'b0;
      auto_in_d_bits_opcode = OP_ACK;
      auto_in_d_bits_size   = '0;
      auto_in_d_bits_source = '0;
      auto_in_d_bits_data   = '0;
      auto_in_d_bits_denied = 1'b0;
      reg_req               = 1'b0;
      reg_we                = 1'b0;
      reg_addr              = '0;
      reg_wdata             = '0;
      reg_be                = '0;
      case (state_q)
         IDLE: auto_in_a_ready = 1'b1;
         BUS: begin
            reg_req   = 1'b1;
            reg_we    = (op_q != OP_GET);
            reg_addr  = addr_q;
            reg_wdata = wdata_q;
            reg_be    = mask_q;
         end
         RESP: begin
            auto_in_d_valid       = 1'b1;
            auto_in_d_bits_opcode = (op_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
            auto_in_d_bits_size   = size_q;
            auto_in_d_bits_source = source_q;
            auto_in_d_bits_data   = rdata_q;
            auto_in_d_bits_denied = denied_q;
         end
         default: ;
      endcase
   end

   logic unused_sig;
   assign unused_sig = ^{auto_in_a_bits_param, corrupt_q};

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// Directed bench for tl_ul_reg_bridge: vector table plus stall, stray-ack, reset and timeout sequences.
module tb_tl_ul_reg_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [1:0]  a_size = '0;
   logic [9:0]  a_source = '0;
   logic [11:0] a_address = '0;
   logic [3:0]  a_mask = '0;
   logic [31:0] a_data = '0;
   logic        a_corrupt = 1'b0;
   logic        d_valid;
   logic        d_ready = 1'b0;
   logic [2:0]  d_opcode;
   logic [1:0]  d_size;
   logic [9:0]  d_source;
   logic [31:0] d_data;
   logic        d_denied;
   logic        reg_req, reg_we;
   logic [11:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic        reg_ack = 1'b0;
   logic [31:0] reg_rdata = '0;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   tl_ul_reg_bridge #(.ADDR_W(12), .SRC_W(10)) dut (
      .clock(clock), .reset(reset),
      .auto_in_a_valid(a_valid), .auto_in_a_ready(a_ready),
      .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
      .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
      .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
      .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
      .auto_in_d_valid(d_valid), .auto_in_d_ready(d_ready),
      .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_size(d_size),
      .auto_in_d_bits_source(d_source), .auto_in_d_bits_data(d_data),
      .auto_in_d_bits_denied(d_denied),
      .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_be(reg_be),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata)
   );

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [9:0]  src;
      logic [11:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic        corrupt;
      int          ack_delay;
      logic [31:0] rdata;
      logic        exp_bus;
      logic        exp_we;
      logic [2:0]  exp_dop;
      logic [31:0] exp_ddata;
      logic        exp_denied;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present one A beat at the current negedge; returns at the negedge after the fire.
   task automatic a_send(input logic [2:0] op, input logic [1:0] size, input logic [9:0] src,
                         input logic [11:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, input logic corrupt);
      a_opcode = op; a_size = size; a_source = src; a_address = addr;
      a_mask = mask; a_data = wdata; a_corrupt = corrupt; a_param = 3'd5;
      a_valid = 1'b1;
      chk("a_ready_before_fire", 32'(a_ready), 32'd1);
      @(negedge clock);
      a_valid = 1'b0;
      a_data = '0; a_mask = '0; a_address = '0; a_source = '0;
   endtask

   task automatic run_vec(input vec_t v);
      a_send(v.op, v.size, v.src, v.addr, v.mask, v.wdata, v.corrupt);
      if (v.exp_bus) begin
         for (int i = 0; i < v.ack_delay; i++) begin
            chk("bus_wait_req", 32'(reg_req), 32'd1);
            chk("bus_wait_dvalid", 32'(d_valid), 32'd0);
            @(negedge clock);
         end
         chk("bus_req", 32'(reg_req), 32'd1);
         chk("bus_we", 32'(reg_we), 32'(v.exp_we));
         chk("bus_addr", 32'(reg_addr), 32'(v.addr));
         chk("bus_be", 32'(reg_be), 32'(v.mask));
         chk("bus_wdata", reg_wdata, v.wdata);
         chk("bus_a_ready", 32'(a_ready), 32'd0);
         reg_ack = 1'b1; reg_rdata = v.rdata;
         @(negedge clock);
         reg_ack = 1'b0; reg_rdata = '0;
      end
      chk("resp_req_low", 32'(reg_req), 32'd0);
      chk("resp_d_valid", 32'(d_valid), 32'd1);
      chk("resp_opcode", 32'(d_opcode), 32'(v.exp_dop));
      chk("resp_size", 32'(d_size), 32'(v.size));
      chk("resp_source", 32'(d_source), 32'(v.src));
      chk("resp_data", d_data, v.exp_ddata);
      chk("resp_denied", 32'(d_denied), 32'(v.exp_denied));
      d_ready = 1'b1;
      @(negedge clock);
      d_ready = 1'b0;
      chk("post_d_a_ready", 32'(a_ready), 32'd1);
      chk("post_d_d_valid", 32'(d_valid), 32'd0);
   endtask

   initial begin
      int n;
      vecs[0] = '{3'd4, 2'd2, 10'h155, 12'h010, 4'hF, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 3'd1, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{3'd1, 2'd1, 10'h0AA, 12'h024, 4'h3, 32'h0000ABCD, 1'b0, 0, 32'h12345678, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0};
      vecs[2] = '{3'd2, 2'd2, 10'h001, 12'h030, 4'hF, 32'h11111111, 1'b0, 0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1};
      vecs[3] = '{3'd0, 2'd2, 10'h3FF, 12'hFFC, 4'hF, 32'hA5A55A5A, 1'b0, 3, 32'h87654321, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0};
      vecs[4] = '{3'd0, 2'd2, 10'h002, 12'h040, 4'hF, 32'hFFFFFFFF, 1'b1, 0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0};
      vecs[5] = '{3'd4, 2'd0, 10'h000, 12'h000, 4'h1, 32'h0, 1'b0, 2, 32'h0BADF00D, 1'b1, 1'b0, 3'd1, 32'h0BADF00D, 1'b0};
      vecs[6] = '{3'd7, 2'd1, 10'h123, 12'h100, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1};
      vecs[7] = '{3'd4, 2'd2, 10'h2AA, 12'h800, 4'hF, 32'h0, 1'b1, 1, 32'h13579BDF, 1'b1, 1'b0, 3'd1, 32'h13579BDF, 1'b0};

      // Reset state
      @(negedge clock);
      chk("rst_reg_req", 32'(reg_req), 32'd0);
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_d_data", d_data, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_a_ready", 32'(a_ready), 32'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Response held under d_ready low; stray ack in RESP must not disturb it
      a_send(3'd4, 2'd2, 10'h0F0, 12'h0A0, 4'hF, 32'h0, 1'b0);
      reg_ack = 1'b1; reg_rdata = 32'hCAFEF00D;
      @(negedge clock);
      reg_rdata = 32'h55555555;
      for (int i = 0; i < 10; i++) begin
         chk("stall_d_valid", 32'(d_valid), 32'd1);
         chk("stall_opcode", 32'(d_opcode), 32'd1);
         chk("stall_source", 32'(d_source), 32'h0F0);
         chk("stall_data", d_data, 32'hCAFEF00D);
         chk("stall_a_ready", 32'(a_ready), 32'd0);
         chk("stall_reg_req", 32'(reg_req), 32'd0);
         @(negedge clock);
      end
      reg_ack = 1'b0; reg_rdata = '0;
      d_ready = 1'b1;
      @(negedge clock);
      d_ready = 1'b0;
      chk("stall_release_a_ready", 32'(a_ready), 32'd1);

      // Ack while idle is ignored
      reg_ack = 1'b1; reg_rdata = 32'hFFFFFFFF;
      repeat (3) begin
         @(negedge clock);
         chk("idle_ack_a_ready", 32'(a_ready), 32'd1);
         chk("idle_ack_d_valid", 32'(d_valid), 32'd0);
         chk("idle_ack_reg_req", 32'(reg_req), 32'd0);
      end
      reg_ack = 1'b0; reg_rdata = '0;

      // Reset while in BUS drops the request with no response
      a_send(3'd4, 2'd2, 10'h077, 12'h0C0, 4'hF, 32'h0, 1'b0);
      chk("pre_reset_req", 32'(reg_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_reset_req", 32'(reg_req), 32'd0);
      chk("mid_reset_d_valid", 32'(d_valid), 32'd0);
      chk("mid_reset_we", 32'(reg_we), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("post_reset_a_ready", 32'(a_ready), 32'd1);
      d_ready = 1'b1;
      n = 0;
      repeat (5) begin
         @(negedge clock);
         if (d_valid) n++;
      end
      d_ready = 1'b0;
      chk("post_reset_no_d", 32'(n), 32'd0);

      // Bus never acknowledged
      a_send(3'd4, 2'd2, 10'h199, 12'h044, 4'hF, 32'h0, 1'b0);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!reg_req) break;
         n++;
         @(negedge clock);
      end
`ifdef TL_REG_BRIDGE_TIMEOUT_EN
      chk("timeout_req_cycles", 32'(n), 32'd255);
      chk("timeout_d_valid", 32'(d_valid), 32'd1);
      chk("timeout_denied", 32'(d_denied), 32'd1);
      chk("timeout_data", d_data, 32'd0);
      chk("timeout_opcode", 32'(d_opcode), 32'd1);
      reg_ack = 1'b1; reg_rdata = 32'h89ABCDEF;
      @(negedge clock);
      reg_ack = 1'b0; reg_rdata = '0;
      chk("late_ack_data", d_data, 32'd0);
      chk("late_ack_denied", 32'(d_denied), 32'd1);
      chk("late_ack_req", 32'(reg_req), 32'd0);
`else
      chk("noack_req_cycles", 32'(n), 32'd300);
      chk("noack_d_valid", 32'(d_valid), 32'd0);
      reg_ack = 1'b1; reg_rdata = 32'h89ABCDEF;
      @(negedge clock);
      reg_ack = 1'b0; reg_rdata = '0;
      chk("noack_late_data", d_data, 32'h89ABCDEF);
      chk("noack_late_denied", 32'(d_denied), 32'd0);
`endif
      d_ready = 1'b1;
      @(negedge clock);
      d_ready = 1'b0;
      chk("final_a_ready", 32'(a_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
